// File: rtl/score_controller_if.sv
// Bundles the collision and start inputs with the score/lives/phase outputs of score_controller.
// The high-score ports exist only when SCORE_CTRL_HIGH_SCORE_EN is defined.
interface score_controller_if;
   logic       start_i;
   logic       goodColl;
   logic       badColl;
   logic [7:0] score_bcd;
   logic [2:0] lives;
   logic       playing;
   logic       hurt;
   logic       game_over;
   logic       game_won;
   logic       score_pulse;
`ifdef SCORE_CTRL_HIGH_SCORE_EN
   logic [7:0] high_score_bcd;
   logic       new_high;
`endif

   modport master (
      output start_i, goodColl, badColl,
      input  score_bcd, lives, playing, hurt, game_over, game_won, score_pulse
`ifdef SCORE_CTRL_HIGH_SCORE_EN
      , input high_score_bcd, new_high
`endif
   );

   modport slave (
      input  start_i, goodColl, badColl,
      output score_bcd, lives, playing, hurt, game_over, game_won, score_pulse
`ifdef SCORE_CTRL_HIGH_SCORE_EN
      , output high_score_bcd, new_high
`endif
   );
endinterface

// File: rtl/score_controller.sv
// Game-level scoring sequencer: BCD score, lives, post-hit invulnerability and win/lose phase.
// Optional high-score register enabled by defining SCORE_CTRL_HIGH_SCORE_EN.
module score_controller #(
   parameter int unsigned LIVES         = 3,
   parameter int unsigned WIN_SCORE     = 20,
   parameter int unsigned INVULN_CYCLES = 4
) (
   input logic          clk,
   input logic          nRst,
   score_controller_if.slave bus
);

   localparam int unsigned     TW         = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
   localparam logic [TW-1:0]   TIMER_LOAD = TW'(INVULN_CYCLES - 1);
   localparam logic [2:0]      LIVES_INIT = 3'(LIVES);
   localparam logic [6:0]      WIN_DEC    = 7'(WIN_SCORE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAY,
      S_HURT,
      S_WIN,
      S_LOSE
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    score_q, score_d;
   logic [2:0]    lives_q, lives_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          pulse_q, pulse_d;

   logic [7:0]    score_inc;
   logic          at_max;
   logic          win_hit;
   logic          good_win;
   logic          out_of_lives;

   function automatic logic [6:0] bcd_to_dec(input logic [7:0] b);
      return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
   endfunction

   // BCD increment; at 99 the result is unused so the score saturates.
   always_comb begin
      at_max = (score_q == 8'h99);
      if (score_q[3:0] == 4'd9) begin
         score_inc = {score_q[7:4] + 4'd1, 4'd0};
      end else begin
         score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
      end
      win_hit = !at_max && (bcd_to_dec(score_inc) == WIN_DEC);
   end

   always_comb begin
      state_d      = state_q;
      score_d      = score_q;
      lives_d      = lives_q;
      timer_d      = timer_q;
      pulse_d      = 1'b0;
      good_win     = 1'b0;
      out_of_lives = 1'b0;

      case (state_q)
         S_IDLE, S_WIN, S_LOSE: begin
            if (bus.start_i) begin
               state_d = S_PLAY;
               score_d = '0;
               lives_d = LIVES_INIT;
               timer_d = '0;
            end
         end

         S_PLAY, S_HURT: begin
            if (bus.goodColl && !at_max) begin
               score_d  = score_inc;
               pulse_d  = 1'b1;
               good_win = win_hit;
            end
            if (state_q == S_PLAY && bus.badColl && lives_q != '0) begin
               lives_d      = lives_q - 3'd1;
               out_of_lives = (lives_q == 3'd1);
            end
            // Losing the last life outranks reaching the winning score.
            if (out_of_lives) begin
               state_d = S_LOSE;
            end else if (good_win) begin
               state_d = S_WIN;
            end else if (state_q == S_PLAY && bus.badColl) begin
               state_d = S_HURT;
               timer_d = TIMER_LOAD;
            end else if (state_q == S_HURT) begin
               if (timer_q == '0) begin
                  state_d = S_PLAY;
               end else begin
                  timer_d = timer_q - TW'(1);
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         state_q <= S_IDLE;
         score_q <= '0;
         lives_q <= LIVES_INIT;
         timer_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         lives_q <= lives_d;
         timer_q <= timer_d;
         pulse_q <= pulse_d;
      end
   end

   assign bus.score_bcd   = score_q;
   assign bus.lives       = lives_q;
   assign bus.playing     = (state_q == S_PLAY) || (state_q == S_HURT);
   assign bus.hurt        = (state_q == S_HURT);
   assign bus.game_over   = (state_q == S_LOSE);
   assign bus.game_won    = (state_q == S_WIN);
   assign bus.score_pulse = pulse_q;

`ifdef SCORE_CTRL_HIGH_SCORE_EN
   logic [7:0] high_q, high_d;
   logic       new_high_q, new_high_d;
   logic       game_end;

   // Captured on the edge that enters WIN/LOSE, using the final score of that edge.
   always_comb begin
      high_d     = high_q;
      new_high_d = 1'b0;
      game_end   = ((state_d == S_WIN) || (state_d == S_LOSE)) &&
                   !((state_q == S_WIN) || (state_q == S_LOSE));
      if (game_end && (bcd_to_dec(score_d) > bcd_to_dec(high_q))) begin
         high_d     = score_d;
         new_high_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         high_q     <= '0;
         new_high_q <= 1'b0;
      end else begin
         high_q     <= high_d;
         new_high_q <= new_high_d;
      end
   end

   assign bus.high_score_bcd = high_q;
   assign bus.new_high       = new_high_q;
`endif

endmodule

// File: doc/score_controller.md
Name: score_controller

Overview:
- Game-level scoring sequencer for the snake datapath.
- Consumes single-cycle goodColl/badColl pulses from the collision edge detector and tracks a 2-digit BCD score, remaining lives and game phase.
- Applies a post-hit invulnerability window.
- Drives the score/lives display and the game-over/win flags used by the top-level controller and renderer.

Parameters:
- LIVES, 3: lives loaded at game start; legal range 1..7.
- WIN_SCORE, 20: decimal score that ends the game as a win; legal range 1..99.
- INVULN_CYCLES, 4: length in cycles of the HURT state after a bad collision; must be ≥1.

Ports:
- clk  in  1  system clock
- nRst  in  1  synchronous active-low reset, sampled on the rising edge of clk
- start_i  in  1  start/restart request, level; acted on only in IDLE/WIN/LOSE
- goodColl  in  1  1-cycle pulse: apple eaten
- badColl  in  1  1-cycle pulse: wall/self hit
- score_bcd  out  8  [7:4] tens digit, [3:0] units digit, BCD
- lives  out  3  remaining lives, binary
- playing  out  1  high in PLAY or HURT
- hurt  out  1  high in HURT
- game_over  out  1  high in LOSE
- game_won  out  1  high in WIN
- score_pulse  out  1  1-cycle pulse, asserted in the cycle score_bcd shows a new value

Behaviour:
- Interface: one clock, clk. Reset nRst is synchronous and active-low. All state updates on the rising edge of clk.
- Reset values:
  - state IDLE, score_bcd 8'h00, lives = LIVES.
  - playing/hurt/game_over/game_won/score_pulse all 0; invulnerability timer 0.
  - Reset asserted mid-game wins over every other input in that cycle.
- States: IDLE, PLAY, HURT, WIN, LOSE. Flag outputs decode directly from the state register (registered, no combinational path from inputs).
- IDLE:
  - Collisions ignored.
  - start_i=1 → PLAY next cycle; score cleared to 00 and lives reloaded to LIVES on the same edge.
- PLAY:
  - goodColl → score increments by 1, visible the next cycle with score_pulse=1 that cycle.
  - BCD increment: units 9→0 carries into tens. 99 saturates: no wrap, no pulse.
  - If the incremented score equals WIN_SCORE → WIN on the same edge.
  - badColl → lives decrements by 1.
    - If lives was 1 → lives 0 and LOSE.
    - Otherwise → HURT, timer loaded with INVULN_CYCLES-1.
  - Simultaneous goodColl and badColl:
    - Both applied: score increments and lives decrements.
    - If the score reaches WIN_SCORE and lives reach 0 in the same cycle, LOSE wins.
    - If the score reaches WIN_SCORE and lives > 0, WIN.
  - start_i ignored.
- HURT:
  - badColl ignored; lives unchanged.
  - goodColl counted exactly as in PLAY, including the WIN transition.
  - Timer decrements each cycle. When the timer is 0 → PLAY next edge, so HURT lasts exactly INVULN_CYCLES cycles.
  - A badColl in the first PLAY cycle after HURT is counted.
- WIN / LOSE:
  - Collisions ignored; score and lives frozen.
  - start_i=1 → PLAY with score 00, lives = LIVES, score_pulse 0.
- score_pulse is never asserted on game-start clears or on reset.
- All arithmetic is unsigned. lives never underflows below 0. Score never exceeds 99.

Optional Feature:
- Macro: SCORE_CTRL_HIGH_SCORE_EN
- Defined:
  - Adds output port high_score_bcd (8 bits, BCD), reset to 8'h00.
  - Updated on entry to WIN or LOSE to the game's final score if that score > the stored value. The comparison is on the BCD value as a decimal number.
  - Survives restarts; cleared only by nRst.
  - Additional output new_high (1 bit), a 1-cycle pulse in the cycle high_score_bcd takes a new value.
- Undefined: neither port exists; no high-score register is synthesized.

Test Plan:
- Reset then start_i=1 for 1 cycle → next cycle playing=1, score_bcd=8'h00, lives=3, score_pulse=0.
- 10 goodColl pulses spaced 3 cycles apart in PLAY → score_bcd steps 01..09 then 8'h10; 10 score_pulses, each 1 cycle after its collision.
- badColl in PLAY with lives=3, followed by badColl 2 cycles later → lives=2; hurt=1 for exactly 4 cycles; the second hit is ignored; playing stays 1.
- Three badColl pulses each spaced ≥5 cycles → lives 2, 1, 0; game_over=1 after the third; further goodColl leaves score unchanged; start_i → PLAY, lives=3, score 00.
- Score at 19 with lives=1, goodColl and badColl in the same cycle → game_over=1, game_won=0, score_bcd=8'h20.
- With SCORE_CTRL_HIGH_SCORE_EN:
  - Game 1 ends at 20 (WIN) → high_score_bcd=8'h20, new_high pulse.
  - Game 2 ends at 05 (LOSE) → high_score_bcd stays 8'h20, no pulse.
  - nRst → 8'h00.
